hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Parametrised successor to the P5 forwarding unit: combined forwarding-select, Tnew/Tuse stall generation and multiply/divide busy tracking for the 5-stage pipeline.
- Source-operand count and register-address width are generic; D and E stage operands are packed vectors.
- Sits beside the D/E/M/W pipeline registers. It drives the forwarding muxes, the F/D enable, the D/E bubble insert and MD-unit status.

Parameters:
- AW, 5, register address width.
- NSRC, 2, source operands per instruction in D and E.
- TW, 2, width of Tnew/Tuse fields.
- MULT_CYC, 5, busy cycles for a multiply (must be ≥1).
- DIV_CYC, 10, busy cycles for a divide (must be ≥1).
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_A  in  NSRC*AW  D-stage source register numbers; operand i occupies bits [i*AW +: AW].
- D_TUSE  in  NSRC*TW  Tuse per D operand.
- D_USE  in  NSRC  operand i actually read.
- D_MD  in  1  D instruction uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- E_A  in  NSRC*AW  E-stage source register numbers.
- M_A2  in  AW  M-stage store-data register.
- A3_E, A3_M, A3_W  in  AW each  destination register in E/M/W.
- E_W, M_W, W_W  in  1 each  register write enable per stage.
- Tnew_E, Tnew_M  in  TW each  cycles until result is available.
- E_MD_START  in  1  mult/div issues in E this cycle.
- E_MD_DIV  in  1  1=divide, 0=multiply; valid with E_MD_START.
- F_D  out  NSRC*2  D forward select per operand: 3 E(pc8/early), 2 M(aluo), 1 W(busw), 0 self.
- F_E  out  NSRC*2  E forward select per operand: 2 M, 1 W, 0 self.
- F_DM  out  1  1 = M store data from W busw.
- stall  out  1  freeze PC and F/D; insert bubble into D/E.
- md_busy  out  1  MD unit computing (registered).
- md_done  out  1  one-cycle pulse when the MD result becomes valid.
- md_ovr  out  1  sticky protocol error: start while busy.
- stall_cnt  out  CNT_W  count of stall cycles, saturating.

Behaviour:
- Reset (async, rst_n=0): md counter=0, md_busy=0, md_done=0, md_ovr=0, stall_cnt=0. Combinational outputs follow their inputs even during reset.
- Match rule (stage S, operand address a): a==A3_S && S_W && A3_S!=0.
- F_D[i]:
  - 3 if E matches and Tnew_E==0.
  - else 2 if M matches and Tnew_M==0.
  - else 1 if W matches.
  - else 0.
  - Youngest stage wins.
- F_E[i]: 2 if M matches and Tnew_M==0; else 1 if W matches; else 0.
- F_DM: 1 iff M_A2 matches W.
- Forward selects are purely combinational; they have zero-cycle latency.
- Data stall, for each i with D_USE[i]=1: stall if (E match && Tnew_E > D_TUSE[i]) or (M match && Tnew_M > D_TUSE[i]).
- MD stall: stall if D_MD && (md_busy || E_MD_START).
- stall = OR of all data-stall and MD-stall terms; combinational.
- MD counter, CW = clog2(max(MULT_CYC,DIV_CYC)+1) bits:
  - E_MD_START while counter==0: load DIV_CYC if E_MD_DIV, else MULT_CYC.
  - counter>0: decrement by 1 per cycle.
  - md_busy = (counter != 0), registered.
  - md_done = 1 for exactly one cycle, the cycle after the counter is 1 (transition 1→0).
- E_MD_START while counter!=0: start ignored, counter keeps decrementing, md_ovr set to 1 until reset.
- Start on the same edge the counter reaches 0 (counter==1 and E_MD_START): treated as busy. Start is ignored and md_ovr is set; the stall rule prevents this in legal code.
- stall_cnt: +1 every cycle stall=1; holds at 2^CNT_W-1 (no wrap).
- Reset asserted mid-operation: counter cleared at once, md_busy/md_done drop asynchronously, and no done pulse follows.

Test Plan:
- Forward priority: A3_E=A3_M=A3_W=5, all W=1, Tnew_E=0, Tnew_M=0, D_A operand0=5 → F_D[1:0]=3. Then Tnew_E=1 → F_D[1:0]=2. Repeat with A3=0 → F_D=0, stall=0.
- Load-use: E lw to $8 (Tnew_E=2, E_W=1), D operand1=8, D_TUSE=1, D_USE=1 → stall=1. Set D_TUSE=2 → stall=0. Set D_USE=0 → stall=0.
- Multiply: pulse E_MD_START, E_MD_DIV=0 → md_busy=1 for 5 cycles, md_done high on cycle 6 only. D_MD=1 during busy → stall=1 every one of those cycles.
- Divide: DIV_CYC=10 → busy 10 cycles. Second E_MD_START at busy cycle 3 → md_ovr=1, busy still ends after cycle 10, md_ovr stays 1.
- Reset mid-divide: rst_n low at busy cycle 4 → md_busy=0 immediately, stall_cnt=0, no md_done after release.
- Saturation: CNT_W=4, hold stall for 20 cycles → stall_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Forwarding-select, Tnew/Tuse stall generation and multiply/divide busy
// tracking for the 5-stage D/E/M/W pipeline. Sits beside the pipeline
// registers and drives the forwarding muxes, the F/D enable, the D/E bubble
// insert and the MD-unit status.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   D_A, D_TUSE, D_USE  D-stage source registers, Tuse and read flags (packed,
//                       operand i in [i*AW +: AW] / [i*TW +: TW] / [i])
//   D_MD                D instruction touches HI/LO
//   E_A                 E-stage source registers (packed)
//   M_A2                M-stage store-data register
//   A3_E/M/W, E/M/W_W   destination register and write enable per stage
//   Tnew_E, Tnew_M      cycles until the E/M result is available
//   E_MD_START/E_MD_DIV mult/div issue in E (DIV=1 divide, 0 multiply)
//   F_D                 D forward select per operand: 3 E, 2 M, 1 W, 0 self
//   F_E                 E forward select per operand: 2 M, 1 W, 0 self
//   F_DM                M store data taken from W
//   stall               freeze PC and F/D, bubble into D/E (combinational)
//   md_busy, md_done    MD unit computing / one-cycle result-valid pulse
//   md_ovr              sticky: start issued while the MD unit was busy
//   stall_cnt           saturating count of stall cycles
//
// MD start protocol: E_MD_START is a single-cycle request sampled on the
// rising edge; it is accepted only when the MD counter is idle (zero).
// A request while the counter is non-zero, including the last busy cycle,
// is dropped and latches md_ovr until reset.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   D_A,
    input  logic [NSRC*TW-1:0]   D_TUSE,
    input  logic [NSRC-1:0]      D_USE,
    input  logic                 D_MD,
    input  logic [NSRC*AW-1:0]   E_A,
    input  logic [AW-1:0]        M_A2,
    input  logic [AW-1:0]        A3_E,
    input  logic [AW-1:0]        A3_M,
    input  logic [AW-1:0]        A3_W,
    input  logic                 E_W,
    input  logic                 M_W,
    input  logic                 W_W,
    input  logic [TW-1:0]        Tnew_E,
    input  logic [TW-1:0]        Tnew_M,
    input  logic                 E_MD_START,
    input  logic                 E_MD_DIV,
    output logic [NSRC*2-1:0]    F_D,
    output logic [NSRC*2-1:0]    F_E,
    output logic                 F_DM,
    output logic                 stall,
    output logic                 md_busy,
    output logic                 md_done,
    output logic                 md_ovr,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int CMAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    logic [CW-1:0]    r_md_cnt;
    logic             r_md_done;
    logic             r_md_ovr;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [NSRC*2-1:0] w_fd;
    logic [NSRC*2-1:0] w_fe;
    logic [AW-1:0]     w_da;
    logic [AW-1:0]     w_ea;
    logic              w_data_stall;
    logic              w_md_stall;
    logic              w_md_active;
    logic              w_e_m, w_m_m, w_w_m;

    assign w_md_active = (r_md_cnt != '0);

    // Match rule: a stage supplies operand a only when it writes a non-zero
    // register equal to a ($0 is never forwarded).
    always_comb begin
        w_fd         = '0;
        w_fe         = '0;
        w_da         = '0;
        w_ea         = '0;
        w_e_m        = 1'b0;
        w_m_m        = 1'b0;
        w_w_m        = 1'b0;
        w_data_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            // D-stage operand: youngest producing stage wins.
            w_da  = D_A[i*AW +: AW];
            w_e_m = (w_da == A3_E) && E_W && (A3_E != '0);
            w_m_m = (w_da == A3_M) && M_W && (A3_M != '0);
            w_w_m = (w_da == A3_W) && W_W && (A3_W != '0);
            if (w_e_m && (Tnew_E == '0))
                w_fd[i*2 +: 2] = 2'd3;
            else if (w_m_m && (Tnew_M == '0))
                w_fd[i*2 +: 2] = 2'd2;
            else if (w_w_m)
                w_fd[i*2 +: 2] = 2'd1;

            // A result not ready by the time the operand is consumed stalls D.
            if (D_USE[i] &&
                ((w_e_m && (Tnew_E > D_TUSE[i*TW +: TW])) ||
                 (w_m_m && (Tnew_M > D_TUSE[i*TW +: TW]))))
                w_data_stall = 1'b1;

            // E-stage operand: only M and W can still supply it.
            w_ea  = E_A[i*AW +: AW];
            w_m_m = (w_ea == A3_M) && M_W && (A3_M != '0);
            w_w_m = (w_ea == A3_W) && W_W && (A3_W != '0);
            if (w_m_m && (Tnew_M == '0))
                w_fe[i*2 +: 2] = 2'd2;
            else if (w_w_m)
                w_fe[i*2 +: 2] = 2'd1;
        end
    end

    // HI/LO users wait while the MD unit is busy or being started in E.
    assign w_md_stall = D_MD && (w_md_active || E_MD_START);

    assign F_D   = w_fd;
    assign F_E   = w_fe;
    assign F_DM  = (M_A2 == A3_W) && W_W && (A3_W != '0);
    assign stall = w_data_stall || w_md_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt    <= '0;
            r_md_done   <= 1'b0;
            r_md_ovr    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // Done pulses in the cycle after the counter's final 1->0 step.
            r_md_done <= (r_md_cnt == CW'(1));
            if (w_md_active) begin
                r_md_cnt <= r_md_cnt - CW'(1);
                if (E_MD_START)
                    r_md_ovr <= 1'b1;
            end else if (E_MD_START) begin
                r_md_cnt <= E_MD_DIV ? CW'(DIV_CYC) : CW'(MULT_CYC);
            end
            if (stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign md_busy   = w_md_active;
    assign md_done   = r_md_done;
    assign md_ovr    = r_md_ovr;
    assign stall_cnt = r_stall_cnt;

endmodule
